// File: rtl/mod_barrett_param_gen_32b_if.sv
// Request/result bundle between a Barrett multiplier front end and the
// parameter generator: modulus request in, K/U result out.
interface mod_barrett_param_gen_32b_if;
  logic        iStart;
  logic [31:0] iMod;
  logic        oBusy;
  logic        oValid;
  logic        oErr;
  logic [5:0]  oK;
  logic [63:0] oU;

  modport master (
    output iStart, iMod,
    input  oBusy, oValid, oErr, oK, oU
  );

  modport slave (
    input  iStart, iMod,
    output oBusy, oValid, oErr, oK, oU
  );
endinterface

// File: rtl/mod_barrett_param_gen_32b.sv
// Barrett parameter generator: K = bitlen(M), U = floor(2^(2K)/M) by a
// bit-serial restoring divider, one quotient bit per enabled clock.
module mod_barrett_param_gen_32b (
  input  logic                           iClk,
  input  logic                           iRstN,
  input  logic                           iEn,
  input  logic                           iClr,
  mod_barrett_param_gen_32b_if.slave     bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  stateR;
  logic [31:0] modR;
  logic [5:0]  kR;
  logic [6:0]  nR;
  logic [32:0] remR;
  logic [63:0] quoR;

  logic [5:0]  kInS;
  logic        dBitS;
  logic [32:0] shRemS;
  logic        geS;
  logic [32:0] remNextS;
  logic [63:0] quoNextS;

  function automatic logic [5:0] bitLen(input logic [31:0] m);
    logic [5:0] len;
    len = 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        len = 6'(i + 1);
      end else begin
        len = len;
      end
    end
    return len;
  endfunction

  // One restoring-division step; the dividend 2^(2K) is a single 1 followed by 2K zeros.
  always_comb begin
    kInS     = bitLen(bus.iMod);
    dBitS    = (nR == {kR, 1'b0});
    shRemS   = 33'({remR, dBitS});
    geS      = (shRemS >= {1'b0, modR});
    remNextS = shRemS;
    if (geS) begin
      remNextS = shRemS - {1'b0, modR};
    end else begin
      remNextS = shRemS;
    end
    quoNextS = 64'({quoR, geS});
  end

  // Control FSM, divider datapath and registered result outputs.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateR     <= IDLE;
      modR       <= 32'd0;
      kR         <= 6'd0;
      nR         <= 7'd0;
      remR       <= 33'd0;
      quoR       <= 64'd0;
      bus.oBusy  <= 1'b0;
      bus.oValid <= 1'b0;
      bus.oErr   <= 1'b0;
      bus.oK     <= 6'd0;
      bus.oU     <= 64'd0;
    end else if (iEn) begin
      if (iClr) begin
        stateR     <= IDLE;
        modR       <= 32'd0;
        kR         <= 6'd0;
        nR         <= 7'd0;
        remR       <= 33'd0;
        quoR       <= 64'd0;
        bus.oBusy  <= 1'b0;
        bus.oValid <= 1'b0;
        bus.oErr   <= 1'b0;
        bus.oK     <= 6'd0;
        bus.oU     <= 64'd0;
      end else begin
        case (stateR)
          IDLE: begin
            if (bus.iStart) begin
              if (bus.iMod == 32'd0) begin
                stateR     <= DONE;
                bus.oValid <= 1'b1;
                bus.oErr   <= 1'b1;
                bus.oK     <= 6'd0;
                bus.oU     <= 64'd0;
              end else begin
                stateR    <= DIV;
                modR      <= bus.iMod;
                kR        <= kInS;
                nR        <= {kInS, 1'b0};
                remR      <= 33'd0;
                quoR      <= 64'd0;
                bus.oBusy <= 1'b1;
              end
            end else begin
              stateR <= IDLE;
            end
          end
          DIV: begin
            remR <= remNextS;
            quoR <= quoNextS;
            if (nR == 7'd0) begin
              stateR     <= DONE;
              bus.oBusy  <= 1'b0;
              bus.oValid <= 1'b1;
              bus.oErr   <= 1'b0;
              bus.oK     <= kR;
              bus.oU     <= quoNextS;
            end else begin
              nR <= nR - 7'd1;
            end
          end
          DONE: begin
            stateR     <= IDLE;
            bus.oValid <= 1'b0;
          end
          default: begin
            stateR     <= IDLE;
            bus.oBusy  <= 1'b0;
            bus.oValid <= 1'b0;
          end
        endcase
      end
    end else begin
      stateR <= stateR;
    end
  end

endmodule

// File: tb/tb_mod_barrett_param_gen_32b.sv
// Bench for the Barrett parameter generator: directed table, handshake corner
// sequences and randomized moduli against an arithmetic reference.
module tb_mod_barrett_param_gen_32b;

  logic iClk;
  logic iRstN;
  logic iEn;
  logic iClr;
  int   total;
  int   bad;

  mod_barrett_param_gen_32b_if bus ();

  mod_barrett_param_gen_32b dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (iEn),
    .iClr  (iClr),
    .bus   (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] m;
    logic [5:0]  k;
    logic [63:0] u;
    logic        err;
    int          lat;
    int          busy;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] refK(input logic [31:0] m);
    int k;
    k = 0;
    while (k < 33 && ((64'd1 << k) <= {32'd0, m})) k++;
    return 6'(k);
  endfunction

  function automatic logic [63:0] refU(input logic [31:0] m);
    logic [95:0] num;
    if (m == 32'd0) return 64'd0;
    num = 96'd1 << (2 * int'(refK(m)));
    return 64'(num / {64'd0, m});
  endfunction

  // Issue one request, count enabled edges until oValid, then step back to IDLE.
  task automatic doReq(input logic [31:0] m, input int gapPct,
                       output int lat, output int busyCnt, output logic gotValid);
    bus.iMod   = m;
    bus.iStart = 1'b1;
    iEn        = 1'b1;
    tick();
    bus.iStart = 1'b0;
    lat        = 0;
    busyCnt    = bus.oBusy ? 1 : 0;
    gotValid   = bus.oValid;
    for (int c = 0; c < 2000 && !gotValid; c++) begin
      iEn = ($urandom_range(99) < gapPct) ? 1'b0 : 1'b1;
      tick();
      if (iEn) lat++;
      if (bus.oBusy) busyCnt++;
      if (bus.oValid) gotValid = 1'b1;
    end
    iEn = 1'b1;
    tick();
  endtask

  initial begin
    int          lat;
    int          busyCnt;
    logic        gotValid;
    int          firstValid;
    int          validCnt;
    logic [31:0] m;

    total      = 0;
    bad        = 0;
    iRstN      = 1'b0;
    iEn        = 1'b0;
    iClr       = 1'b0;
    bus.iStart = 1'b0;
    bus.iMod   = 32'd0;

    vecs[0] = '{32'd7681,       6'd13, 64'd8736,          1'b0, 27, 27};
    vecs[1] = '{32'hFFFF_FFFF,  6'd32, 64'h1_0000_0001,   1'b0, 65, 65};
    vecs[2] = '{32'h8000_0000,  6'd32, 64'h2_0000_0000,   1'b0, 65, 65};
    vecs[3] = '{32'd0,          6'd0,  64'd0,             1'b1, 0,  0};
    vecs[4] = '{32'd1,          6'd1,  64'd4,             1'b0, 3,  3};
    vecs[5] = '{32'd3,          6'd2,  64'd5,             1'b0, 5,  5};
    vecs[6] = '{32'd2,          6'd2,  64'd8,             1'b0, 5,  5};
    vecs[7] = '{32'h0001_0000,  6'd17, 64'h4_0000,        1'b0, 35, 35};

    tick();
    check("rst_busy",  64'(bus.oBusy),  64'd0);
    check("rst_valid", 64'(bus.oValid), 64'd0);
    check("rst_err",   64'(bus.oErr),   64'd0);
    check("rst_k",     64'(bus.oK),     64'd0);
    check("rst_u",     bus.oU,          64'd0);
    #2 iRstN = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      doReq(vecs[i].m, 0, lat, busyCnt, gotValid);
      check("tbl_valid", 64'(gotValid), 64'd1);
      check("tbl_lat",   64'(lat),      64'(vecs[i].lat));
      check("tbl_busy",  64'(busyCnt),  64'(vecs[i].busy));
      check("tbl_k",     64'(bus.oK),   64'(vecs[i].k));
      check("tbl_u",     bus.oU,        vecs[i].u);
      check("tbl_err",   64'(bus.oErr), 64'(vecs[i].err));
      check("tbl_vdrop", 64'(bus.oValid), 64'd0);
    end

    // Freeze for 5 cycles mid-division plus ignored start pulses with M=3.
    bus.iMod   = 32'd7681;
    bus.iStart = 1'b1;
    iEn        = 1'b1;
    tick();
    firstValid = -1;
    for (int c = 1; c <= 100 && firstValid < 0; c++) begin
      iEn        = (c >= 11 && c <= 15) ? 1'b0 : 1'b1;
      bus.iStart = (c == 3 || c == 20) ? 1'b1 : 1'b0;
      bus.iMod   = (c == 3 || c == 20) ? 32'd3 : 32'd7681;
      tick();
      if (bus.oValid) firstValid = c;
    end
    bus.iStart = 1'b0;
    check("gap_lat", 64'(firstValid), 64'd32);
    check("gap_k",   64'(bus.oK),     64'd13);
    check("gap_u",   bus.oU,          64'd8736);
    iEn = 1'b0;
    tick();
    tick();
    check("gap_stretch", 64'(bus.oValid), 64'd1);
    iEn = 1'b1;
    tick();
    check("gap_vdrop", 64'(bus.oValid), 64'd0);

    // Asynchronous reset in the middle of a division.
    bus.iMod   = 32'hFFFF_FFFF;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    #2 iRstN = 1'b0;
    #1;
    check("arst_busy", 64'(bus.oBusy), 64'd0);
    check("arst_k",    64'(bus.oK),    64'd0);
    check("arst_u",    bus.oU,         64'd0);
    tick();
    #2 iRstN = 1'b1;
    validCnt = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (bus.oValid) validCnt++;
    end
    check("arst_novalid", 64'(validCnt), 64'd0);
    doReq(32'd3, 0, lat, busyCnt, gotValid);
    check("arst_lat", 64'(lat),    64'd5);
    check("arst_k2",  64'(bus.oK), 64'd2);
    check("arst_u2",  bus.oU,      64'd5);

    // Synchronous clear in the middle of a division.
    bus.iMod   = 32'hFFFF_FFFF;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    check("clr_busy",  64'(bus.oBusy),  64'd0);
    check("clr_valid", 64'(bus.oValid), 64'd0);
    check("clr_k",     64'(bus.oK),     64'd0);
    check("clr_u",     bus.oU,          64'd0);
    validCnt = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (bus.oValid) validCnt++;
    end
    check("clr_novalid", 64'(validCnt), 64'd0);
    doReq(32'd3, 0, lat, busyCnt, gotValid);
    check("clr_lat", 64'(lat),    64'd5);
    check("clr_k2",  64'(bus.oK), 64'd2);
    check("clr_u2",  bus.oU,      64'd5);

    // Random moduli with random enable gaps.
    for (int i = 0; i < 200; i++) begin
      m = $urandom >> $urandom_range(31);
      if (m == 32'd0) m = 32'd1;
      doReq(m, 20, lat, busyCnt, gotValid);
      check("rnd_valid", 64'(gotValid), 64'd1);
      check("rnd_lat",   64'(lat),      64'(2 * int'(refK(m)) + 1));
      check("rnd_k",     64'(bus.oK),   64'(refK(m)));
      check("rnd_u",     bus.oU,        refU(m));
      check("rnd_err",   64'(bus.oErr), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
